// File: rtl/loop_mixer.sv
// Saturating stereo mixer for NUM_TRACKS volume-scaled loop tracks.
// Sums one track per cycle, then holds the mixed frame for the codec write handshake.
module loop_mixer #(
  parameter int NUM_TRACKS = 4,
  parameter int WIDTH      = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_TRACKS*WIDTH-1:0] track_left,
  input  logic [NUM_TRACKS*WIDTH-1:0] track_right,
  input  logic [NUM_TRACKS-1:0]       track_enable,
  input  logic                        audio_out_allowed,
  output logic                        write_audio_out,
  output logic [WIDTH-1:0]            left_channel_audio_out,
  output logic [WIDTH-1:0]            right_channel_audio_out,
  output logic                        clip_left,
  output logic                        clip_right,
  input  logic                        clip_clear,
  output logic [15:0]                 overrun_count
);

  localparam int ACC_W = WIDTH + 3;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {IDLE, SUM, WAIT} state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0] idx_reg;
  logic [ACC_W-1:0] acc_left_reg, acc_right_reg;
  logic [ACC_W-1:0] sum_left, sum_right;
  logic [WIDTH-1:0] sat_left, sat_right;
  logic             ovf_left, ovf_right;
  logic             last_step;
  logic             capture;

  logic [WIDTH-1:0] masked_left   [NUM_TRACKS];
  logic [WIDTH-1:0] masked_right  [NUM_TRACKS];
  logic [WIDTH-1:0] cap_left_reg  [NUM_TRACKS];
  logic [WIDTH-1:0] cap_right_reg [NUM_TRACKS];

  assign capture   = (state_reg == IDLE) && in_valid;
  assign last_step = (idx_reg == CNT_W'(NUM_TRACKS - 1));

  // Captured tracks form a shift register: element 0 is always the track
  // being added, so no wide read mux is needed.
  generate
    for (genvar gi = 0; gi < NUM_TRACKS; gi++) begin : g_track
      assign masked_left[gi]  = track_enable[gi] ? track_left[gi*WIDTH +: WIDTH]  : '0;
      assign masked_right[gi] = track_enable[gi] ? track_right[gi*WIDTH +: WIDTH] : '0;

      if (gi == NUM_TRACKS - 1) begin : g_last
        always_ff @(posedge clk) begin
          if (reset) begin
            cap_left_reg[gi]  <= '0;
            cap_right_reg[gi] <= '0;
          end else if (capture) begin
            cap_left_reg[gi]  <= masked_left[gi];
            cap_right_reg[gi] <= masked_right[gi];
          end
        end
      end else begin : g_mid
        always_ff @(posedge clk) begin
          if (reset) begin
            cap_left_reg[gi]  <= '0;
            cap_right_reg[gi] <= '0;
          end else if (capture) begin
            cap_left_reg[gi]  <= masked_left[gi];
            cap_right_reg[gi] <= masked_right[gi];
          end else if (state_reg == SUM) begin
            cap_left_reg[gi]  <= cap_left_reg[gi+1];
            cap_right_reg[gi] <= cap_right_reg[gi+1];
          end
        end
      end
    end
  endgenerate

  assign sum_left  = acc_left_reg  + {{3{cap_left_reg[0][WIDTH-1]}},  cap_left_reg[0]};
  assign sum_right = acc_right_reg + {{3{cap_right_reg[0][WIDTH-1]}}, cap_right_reg[0]};

  // Out of range exactly when the bits above the result sign disagree with it.
  assign ovf_left  = (sum_left[ACC_W-1:WIDTH-1]  != {4{sum_left[ACC_W-1]}});
  assign ovf_right = (sum_right[ACC_W-1:WIDTH-1] != {4{sum_right[ACC_W-1]}});

  always_comb begin
    sat_left = sum_left[WIDTH-1:0];
    if (ovf_left) begin
      sat_left = sum_left[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
    sat_right = sum_right[WIDTH-1:0];
    if (ovf_right) begin
      sat_right = sum_right[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    in_ready        = 1'b0;
    write_audio_out = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = SUM;
        end
      end
      SUM: begin
        if (last_step) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        write_audio_out = audio_out_allowed && !reset;
        if (write_audio_out) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_reg                 <= '0;
      acc_left_reg            <= '0;
      acc_right_reg           <= '0;
      left_channel_audio_out  <= '0;
      right_channel_audio_out <= '0;
      clip_left               <= 1'b0;
      clip_right              <= 1'b0;
      overrun_count           <= '0;
    end else begin
      if (in_valid && (state_reg != IDLE) && (overrun_count != 16'hFFFF)) begin
        overrun_count <= overrun_count + 16'd1;
      end

      if (capture) begin
        idx_reg       <= '0;
        acc_left_reg  <= '0;
        acc_right_reg <= '0;
      end else if (state_reg == SUM) begin
        idx_reg       <= idx_reg + CNT_W'(1);
        acc_left_reg  <= sum_left;
        acc_right_reg <= sum_right;
        if (last_step) begin
          left_channel_audio_out  <= sat_left;
          right_channel_audio_out <= sat_right;
        end
      end

      // A fresh saturation takes priority over a simultaneous clear.
      if ((state_reg == SUM) && last_step && ovf_left) begin
        clip_left <= 1'b1;
      end else if (clip_clear) begin
        clip_left <= 1'b0;
      end
      if ((state_reg == SUM) && last_step && ovf_right) begin
        clip_right <= 1'b1;
      end else if (clip_clear) begin
        clip_right <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_loop_mixer.sv
// Self-checking bench for loop_mixer: expected frames are queued at stimulus time
// and compared by a monitor whenever the mixer issues a codec write.
module tb_loop_mixer;

  localparam int NT = 4;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [NT*W-1:0] track_left = '0;
  logic [NT*W-1:0] track_right = '0;
  logic [NT-1:0]   track_enable = '0;
  logic            audio_out_allowed = 1'b1;
  logic            write_audio_out;
  logic [W-1:0]    left_channel_audio_out;
  logic [W-1:0]    right_channel_audio_out;
  logic            clip_left;
  logic            clip_right;
  logic            clip_clear = 1'b0;
  logic [15:0]     overrun_count;

  int vectors = 0;
  int miscompares = 0;
  int write_cnt = 0;
  logic [2*W-1:0] exp_q[$];

  loop_mixer #(.NUM_TRACKS(NT), .WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .track_left(track_left),
    .track_right(track_right),
    .track_enable(track_enable),
    .audio_out_allowed(audio_out_allowed),
    .write_audio_out(write_audio_out),
    .left_channel_audio_out(left_channel_audio_out),
    .right_channel_audio_out(right_channel_audio_out),
    .clip_left(clip_left),
    .clip_right(clip_right),
    .clip_clear(clip_clear),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  // Write monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (write_audio_out) begin
      logic [2*W-1:0] e;
      write_cnt++;
      vectors++;
      $display("write L=%h R=%h", left_channel_audio_out, right_channel_audio_out);
      if (reset || !audio_out_allowed) begin
        miscompares++;
        $display("FAIL write_gate: write=1 with reset=%b allowed=%b, required write=0", reset, audio_out_allowed);
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got L=%h R=%h, required no write", left_channel_audio_out, right_channel_audio_out);
      end else begin
        e = exp_q.pop_front();
        if ({left_channel_audio_out, right_channel_audio_out} !== e) begin
          miscompares++;
          $display("FAIL frame: got L=%h R=%h, required L=%h R=%h",
                   left_channel_audio_out, right_channel_audio_out, e[2*W-1:W], e[W-1:0]);
        end
      end
    end
  end

  function automatic logic [NT*W-1:0] pack4(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] c, input logic [W-1:0] d);
    return {d, c, b, a};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at capture edge + 1.
  task automatic send(input logic [NT-1:0] en, input logic [NT*W-1:0] l, input logic [NT*W-1:0] r);
    track_enable = en;
    track_left   = l;
    track_right  = r;
    in_valid     = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    for (k = 0; k < 60; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_timeout: %0d frames still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (write_audio_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_write: got %b required 0", write_audio_out);
    end
    tick(2);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({in_ready, write_audio_out, clip_left, clip_right, overrun_count, left_channel_audio_out, right_channel_audio_out}
        !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b wr=%b cl=%b cr=%b ov=%h L=%h R=%h, required rdy=1 others 0",
               in_ready, write_audio_out, clip_left, clip_right, overrun_count,
               left_channel_audio_out, right_channel_audio_out);
    end
    tick(1);
  endtask

  task automatic test_single;
    int lat = -1;
    exp_q.push_back({32'h000003E8, 32'hFFFFFC18});
    send(4'b0001, pack4(32'h000003E8, 32'h11111111, 32'h22222222, 32'h33333333),
                  pack4(32'hFFFFFC18, 32'h44444444, 32'h55555555, 32'h66666666));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (write_audio_out) begin
        lat = k;
        break;
      end
    end
    vectors++;
    if (lat != 4) begin
      miscompares++;
      $display("FAIL single_latency: write seen %0d cycles after capture, required 4", lat);
    end
    drain("single");
    vectors++;
    if ({clip_left, clip_right} !== 2'b00) begin
      miscompares++;
      $display("FAIL single_clip: got %b%b required 00", clip_left, clip_right);
    end
  endtask

  task automatic test_saturation;
    exp_q.push_back({32'h7FFFFFFF, 32'h80000000});
    send(4'b1111, {4{32'h40000000}}, {4{32'hC0000000}});
    drain("saturation");
    vectors++;
    if ({clip_left, clip_right} !== 2'b11) begin
      miscompares++;
      $display("FAIL sat_clip: got %b%b required 11", clip_left, clip_right);
    end
    clip_clear = 1'b1;
    tick(1);
    clip_clear = 1'b0;
    vectors++;
    if ({clip_left, clip_right} !== 2'b00) begin
      miscompares++;
      $display("FAIL clip_clear: got %b%b required 00", clip_left, clip_right);
    end
  endtask

  task automatic test_backpressure;
    int w0;
    w0 = write_cnt;
    audio_out_allowed = 1'b0;
    exp_q.push_back({32'h00000064, 32'hFFFFFF9C});
    send(4'b0001, pack4(32'h64, 32'h0, 32'h0, 32'h0), pack4(32'hFFFFFF9C, 32'h0, 32'h0, 32'h0));
    tick(7);
    send(4'b1111, {4{32'h00000777}}, {4{32'h00000888}});
    tick(3);
    send(4'b1111, {4{32'h00000999}}, {4{32'h00000AAA}});
    tick(8);
    vectors++;
    if (overrun_count !== 16'd2) begin
      miscompares++;
      $display("FAIL bp_overrun: got %0d required 2", overrun_count);
    end
    vectors++;
    if (write_cnt != w0) begin
      miscompares++;
      $display("FAIL bp_held: got %0d writes while blocked, required 0", write_cnt - w0);
    end
    audio_out_allowed = 1'b1;
    drain("backpressure");
    tick(6);
    vectors++;
    if (write_cnt - w0 != 1 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: got writes=%0d rdy=%b, required writes=1 rdy=1", write_cnt - w0, in_ready);
    end
  endtask

  task automatic test_enable_mask;
    exp_q.push_back({32'd40, 32'd4});
    send(4'b0101, pack4(32'd10, 32'd20, 32'd30, 32'd40), pack4(32'd1, 32'd2, 32'd3, 32'd4));
    drain("enable");
    vectors++;
    if ({clip_left, clip_right} !== 2'b00) begin
      miscompares++;
      $display("FAIL enable_clip: got %b%b required 00", clip_left, clip_right);
    end
  endtask

  task automatic test_reset_in_sum;
    int w0;
    w0 = write_cnt;
    send(4'b1111, {4{32'h00001000}}, {4{32'h00002000}});
    tick(2);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({in_ready, overrun_count, left_channel_audio_out, right_channel_audio_out, clip_left, clip_right}
        !== {1'b1, 16'h0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL sum_reset_state: got rdy=%b ov=%h L=%h R=%h cl=%b cr=%b, required rdy=1 others 0",
               in_ready, overrun_count, left_channel_audio_out, right_channel_audio_out, clip_left, clip_right);
    end
    tick(10);
    vectors++;
    if (write_cnt != w0) begin
      miscompares++;
      $display("FAIL sum_reset_nowrite: got %0d writes required 0", write_cnt - w0);
    end
    exp_q.push_back({32'h00000006, 32'hFFFFFFFA});
    send(4'b0111, pack4(32'd1, 32'd2, 32'd3, 32'd100), pack4(-32'sd1, -32'sd2, -32'sd3, 32'd100));
    drain("after_reset");
  endtask

  task automatic test_back_to_back;
    int w0;
    w0 = write_cnt;
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back({32'(f * 4 + 4), 32'(-(f + 1) * 4)});
      send(4'b1111, {4{32'(f + 1)}}, {4{32'(-(f + 1))}});
      if (f < 2) tick(5);
    end
    drain("b2b");
    vectors++;
    if (overrun_count !== 16'd0) begin
      miscompares++;
      $display("FAIL b2b_overrun: got %0d required 0", overrun_count);
    end
    tick(2);
    exp_q.push_back({32'd400, 32'd800});
    send(4'b1111, {4{32'd100}}, {4{32'd200}});
    tick(4);
    send(4'b1111, {4{32'd5}}, {4{32'd6}});
    drain("b2b_short");
    tick(6);
    vectors++;
    if (overrun_count !== 16'd1 || write_cnt - w0 != 4) begin
      miscompares++;
      $display("FAIL b2b_short: got ov=%0d writes=%0d, required ov=1 writes=4", overrun_count, write_cnt - w0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturation();
    test_backpressure();
    test_enable_mask();
    test_reset_in_sum();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/loop_mixer.md
Name: loop_mixer

Overview:
Downstream stage of the per-track volume blocks. Sums the volume-scaled 32-bit signed stereo samples of NUM_TRACKS loop tracks with saturation. Presents the mixed frame to the audio codec output FIFO using the codec's write_audio_out / audio_out_allowed handshake. Holds one frame, counts dropped frames and flags clipping.

Parameters:
NUM_TRACKS, 4, number of track inputs summed (1..8)
WIDTH, 32, sample width in bits, two's complement signed

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  one-cycle strobe: new frame on track_left/track_right
in_ready  out  1  high when a frame strobe will be accepted
track_left  in  NUM_TRACKS*WIDTH  packed left samples; track i at bits [i*WIDTH +: WIDTH]
track_right  in  NUM_TRACKS*WIDTH  packed right samples, same packing
track_enable  in  NUM_TRACKS  bit i high: track i included in the mix
audio_out_allowed  in  1  codec output FIFO has space
write_audio_out  out  1  codec write strobe
left_channel_audio_out  out  WIDTH  mixed left sample
right_channel_audio_out  out  WIDTH  mixed right sample
clip_left  out  1  sticky: a left mix saturated
clip_right  out  1  sticky: a right mix saturated
clip_clear  in  1  clears both clip flags
overrun_count  out  16  frames dropped because the block was busy

Behaviour:
- Reset:
  - State goes to IDLE; accumulators are cleared.
  - All outputs are 0 except in_ready, which is 1 from the first cycle after reset.
  - write_audio_out is forced to 0 in any cycle where reset is high.
- States: IDLE, SUM, WAIT.
- IDLE:
  - in_ready=1.
  - When in_valid is sampled high, all track samples and track_enable are captured. Disabled tracks are captured as 0.
  - Accumulators and the track index are cleared; the next state is SUM.
- SUM:
  - On each edge, the accumulator adds the captured track at the current index, sign-extended. The track index increments.
  - The accumulator is WIDTH+3 bits wide.
  - After NUM_TRACKS edges, saturate to WIDTH bits:
    - a value > 2^(WIDTH-1)-1 gives 0x7FFFFFFF;
    - a value < -2^(WIDTH-1) gives 0x80000000.
  - The saturated values are registered into the *_audio_out outputs; the next state is WAIT.
  - Saturation on a channel sets that channel's clip flag in the same edge.
- WAIT:
  - write_audio_out = audio_out_allowed (combinational, gated by reset).
  - On an edge where write_audio_out is high, the next state is IDLE.
  - The *_audio_out outputs stay stable from WAIT entry until the next SUM completes.
- Timing:
  - Latency: in_valid sampled at edge E0 gives WAIT from E0+NUM_TRACKS. The write pulse can occur in the cycle after that edge.
  - Minimum accepted frame spacing is NUM_TRACKS+2 cycles.
  - write_audio_out is high for exactly one cycle per accepted frame.
- Overrun:
  - in_valid while state != IDLE drops the frame; in_ready=0 in SUM and WAIT.
  - Each dropped frame increments overrun_count, saturating at 0xFFFF.
  - The captured frame is not disturbed.
- Simultaneous events:
  - in_valid in the WAIT cycle where the write occurs is dropped and counted.
  - clip_clear together with a new saturation: set wins.
  - Reset mid-SUM or mid-WAIT: the frame is discarded and no write is issued; overrun_count and the clip flags clear.

Test Plan:
1. Single-track path:
   - Stimulus: enable=0001, track0 L=0x000003E8, R=0xFFFFFC18, audio_out_allowed=1.
   - Required: one write_audio_out pulse 4 cycles after the capture edge, with L=0x000003E8, R=0xFFFFFC18, clip flags 0.
2. Saturation:
   - Stimulus: enable=1111, all L=0x40000000, all R=0xC0000000.
   - Required: L=0x7FFFFFFF, R=0x80000000, clip_left=1, clip_right=1.
   - Then clip_clear pulse: both flags 0.
3. Backpressure and overrun:
   - Stimulus: audio_out_allowed=0 for 20 cycles; in_valid pulses at capture, +8, +12; then allowed=1.
   - Required: no write while allowed=0, overrun_count=2, then exactly one write carrying the first frame, in_ready=1 afterwards.
4. Enable masking:
   - Stimulus: enable=0101, L tracks 0..3 = 10,20,30,40.
   - Required: L=40 (tracks 0 and 2 only), no clip.
5. Reset during SUM:
   - Stimulus: assert reset 2 cycles after capture.
   - Required: no write pulse, outputs 0, overrun_count 0, in_ready=1 the cycle after reset deasserts. A following frame mixes correctly.
6. Back-to-back frames at minimum spacing (NUM_TRACKS+2) with allowed=1:
   - Required: every frame written once, overrun_count stays 0.
   - in_valid one cycle earlier than that spacing: that frame is dropped and overrun_count=1.
